// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
//   req/we/addr/be/wdata : request payload, held stable by the master until gnt
//   gnt                  : slave accepts the request in this cycle
//   rvalid/rdata         : load response, one cycle, after the grant cycle
interface lsu_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned NB = XLEN / 8;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NB-1:0]         be;
  logic [XLEN-1:0]       wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [XLEN-1:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one operation at a time from execute, performs
// byte-lane alignment for stores and extraction/extension for loads, and
// returns a registered writeback with single-cycle fault pulses.
//   clk, rst               : clock, synchronous active-high reset
//   valid_i .. wreg_data_i : operation from execute (held while stall_o)
//   stall_o                : high while a memory transaction is in flight
//   valid_o .. illegal_o   : registered writeback and fault pulses
//   dmem                   : data-memory bus (master side)
module lsu #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      wmem_en_i,
  input  logic                      rmem_en_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic                      wreg_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wreg_addr_i,
  input  logic [XLEN-1:0]           wreg_data_i,
  output logic                      stall_o,
  output logic                      valid_o,
  output logic                      wreg_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wreg_addr_o,
  output logic [XLEN-1:0]           wreg_data_o,
  output logic                      misalign_o,
  output logic                      illegal_o,
  lsu_if.master                     dmem
);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFF = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      valid_q, valid_d;
  logic                      misalign_q, misalign_d;
  logic                      illegal_q, illegal_d;
  logic                      wreg_en_out_q, wreg_en_out_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_addr_out_q, wreg_addr_out_d;
  logic [XLEN-1:0]           wreg_data_out_q, wreg_data_out_d;
  logic                      req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic [NB-1:0]             req_be_q, req_be_d;
  logic [XLEN-1:0]           req_wdata_q, req_wdata_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [OFF-1:0]            off_q, off_d;
  logic                      wreg_en_q, wreg_en_d;

  logic                      is_mem, legal, misaligned;
  logic [NB-1:0]             size_mask;
  logic [OFF-1:0]            off_in;
  logic [XLEN-1:0]           rshift, load_data;

  assign off_in = addr_i[OFF-1:0];

  // Decode of the operation currently presented; wmem_en_i wins over rmem_en_i.
  always_comb begin
    is_mem     = wmem_en_i | rmem_en_i;
    legal      = 1'b0;
    misaligned = 1'b0;
    size_mask  = '0;
    if (wmem_en_i) begin
      legal = (funct3_i <= 3'd2) || ((XLEN == 64) && (funct3_i == 3'd3));
    end else begin
      case (funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
        3'd3, 3'd6:                   legal = (XLEN == 64);
        default:                      legal = 1'b0;
      endcase
    end
    case (funct3_i[1:0])
      2'd0: begin misaligned = 1'b0;          size_mask = NB'(8'h01); end
      2'd1: begin misaligned = addr_i[0];     size_mask = NB'(8'h03); end
      2'd2: begin misaligned = |addr_i[1:0];  size_mask = NB'(8'h0F); end
      default: begin misaligned = |addr_i[2:0]; size_mask = NB'(8'hFF); end
    endcase
  end

  // Load result: shift the addressed lane down, then extend by size/sign code.
  always_comb begin
    rshift = dmem.rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_data = XLEN'($signed(rshift[7:0]));
      3'd1:    load_data = XLEN'($signed(rshift[15:0]));
      3'd2:    load_data = XLEN'($signed(rshift[31:0]));
      3'd4:    load_data = XLEN'(rshift[7:0]);
      3'd5:    load_data = XLEN'(rshift[15:0]);
      3'd6:    load_data = XLEN'(rshift[31:0]);
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = 1'b0;
    misalign_d      = 1'b0;
    illegal_d       = 1'b0;
    wreg_en_out_d   = 1'b0;
    wreg_addr_out_d = wreg_addr_out_q;
    wreg_data_out_d = wreg_data_out_q;
    req_we_d        = req_we_q;
    req_addr_d      = req_addr_q;
    req_be_d        = req_be_q;
    req_wdata_d     = req_wdata_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    wreg_en_d       = wreg_en_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (valid_i) begin
          wreg_addr_out_d = wreg_addr_i;
          wreg_en_d       = wreg_en_i;
          funct3_d        = funct3_i;
          off_d           = off_in;
          if (!is_mem) begin
            valid_d         = 1'b1;
            wreg_en_out_d   = wreg_en_i;
            wreg_data_out_d = wreg_data_i;
          end else if (!legal) begin
            valid_d   = 1'b1;
            illegal_d = 1'b1;
          end else if (misaligned) begin
            valid_d    = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_we_d    = wmem_en_i;
            req_addr_d  = {addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            req_be_d    = size_mask << off_in;
            req_wdata_d = wdata_i << {off_in, 3'b000};
          end
        end
      end
      S_REQ: begin
        if (dmem.gnt) begin
          state_d = req_we_q ? S_DONE : S_WAIT;
          valid_d = req_we_q;
        end
      end
      S_WAIT: begin
        if (dmem.rvalid) begin
          state_d         = S_DONE;
          valid_d         = 1'b1;
          wreg_en_out_d   = wreg_en_q;
          wreg_data_out_d = load_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      valid_q         <= 1'b0;
      misalign_q      <= 1'b0;
      illegal_q       <= 1'b0;
      wreg_en_out_q   <= 1'b0;
      wreg_addr_out_q <= '0;
      wreg_data_out_q <= '0;
      req_we_q        <= 1'b0;
      req_addr_q      <= '0;
      req_be_q        <= '0;
      req_wdata_q     <= '0;
      funct3_q        <= '0;
      off_q           <= '0;
      wreg_en_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      misalign_q      <= misalign_d;
      illegal_q       <= illegal_d;
      wreg_en_out_q   <= wreg_en_out_d;
      wreg_addr_out_q <= wreg_addr_out_d;
      wreg_data_out_q <= wreg_data_out_d;
      req_we_q        <= req_we_d;
      req_addr_q      <= req_addr_d;
      req_be_q        <= req_be_d;
      req_wdata_q     <= req_wdata_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      wreg_en_q       <= wreg_en_d;
    end
  end

  assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;
  assign illegal_o   = illegal_q;
  assign wreg_en_o   = wreg_en_out_q;
  assign wreg_addr_o = wreg_addr_out_q;
  assign wreg_data_o = wreg_data_out_q;
  assign dmem.req    = (state_q == S_REQ);
  assign dmem.we     = req_we_q;
  assign dmem.addr   = req_addr_q;
  assign dmem.be     = req_be_q;
  assign dmem.wdata  = req_wdata_q;
endmodule
